// File: rtl/pipe_hazard_ctrl_pkg.sv
// riscv_pipe_pkg: shared opcodes, forward selects and FSM state.
// Imported by the hazard controller, its interface and sub-module.
package riscv_pipe_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_MEMWAIT = 2'd3
  } pipe_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM/WB info in, stage control out.
// master = pipeline side, slave = controller. Perf: PIPE_HAZARD_PERF_EN.
interface pipe_hazard_ctrl_if
`ifdef PIPE_HAZARD_PERF_EN
  #(parameter int PERF_W = 32)
`endif
  ;
  logic [31:0] id_instr;
  logic        id_valid;
  logic [4:0]  ex_rd;
  logic        ex_memread;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic        ex_redirect;
  logic [4:0]  mem_rd;
  logic        mem_regwrite;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic        dmem_req;
  logic        dmem_ack;
  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        flush_if_id;
  logic        bubble_id_ex;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [1:0]  ctrl_state;
`ifdef PIPE_HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_stall_cnt;
  logic [PERF_W-1:0] perf_flush_cnt;
`endif

  modport master (
    output id_instr, id_valid,
    output ex_rd, ex_memread,
    output ex_rs1, ex_rs2, ex_redirect,
    output mem_rd, mem_regwrite,
    output wb_rd, wb_regwrite,
    output dmem_req, dmem_ack,
    input  pc_en, if_id_en, id_ex_en,
    input  ex_mem_en, mem_wb_en,
    input  flush_if_id, bubble_id_ex,
    input  fwd_a, fwd_b, ctrl_state
`ifdef PIPE_HAZARD_PERF_EN
    , input perf_stall_cnt, perf_flush_cnt
`endif
  );

  modport slave (
    input  id_instr, id_valid,
    input  ex_rd, ex_memread,
    input  ex_rs1, ex_rs2, ex_redirect,
    input  mem_rd, mem_regwrite,
    input  wb_rd, wb_regwrite,
    input  dmem_req, dmem_ack,
    output pc_en, if_id_en, id_ex_en,
    output ex_mem_en, mem_wb_en,
    output flush_if_id, bubble_id_ex,
    output fwd_a, fwd_b, ctrl_state
`ifdef PIPE_HAZARD_PERF_EN
    , output perf_stall_cnt, perf_flush_cnt
`endif
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: ID register-usage decode, load-use compare, EX forwarding.
// In: ID instr/valid, EX/MEM/WB regs. Out: o_load_use, o_fwd_a, o_fwd_b.
module hazard_detect
  import riscv_pipe_pkg::*;
(
  input  logic [31:0] i_id_instr,
  input  logic        i_id_valid,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_memread,
  input  logic [4:0]  i_ex_rs1,
  input  logic [4:0]  i_ex_rs2,
  input  logic [4:0]  i_mem_rd,
  input  logic        i_mem_regwrite,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_wb_regwrite,
  output logic        o_load_use,
  output fwd_sel_t    o_fwd_a,
  output fwd_sel_t    o_fwd_b
);

  logic [6:0] w_opc;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_use_rs1;
  logic       w_use_rs2;

  assign w_opc = i_id_instr[6:0];
  assign w_rs1 = i_id_instr[19:15];
  assign w_rs2 = i_id_instr[24:20];

  always_comb begin
    w_use_rs1 = 1'b1;
    w_use_rs2 = 1'b0;
    case (w_opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL:
        w_use_rs1 = 1'b0;
      OPC_OP, OPC_STORE, OPC_BRANCH:
        w_use_rs2 = 1'b1;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: ;
      default: ;
    endcase
  end

  // x0 is excluded once here via ex_rd, so the source match needs no check.
  assign o_load_use = i_ex_memread
                    && (i_ex_rd != 5'd0)
                    && i_id_valid
                    && ((w_use_rs1 && (w_rs1 == i_ex_rd))
                     || (w_use_rs2 && (w_rs2 == i_ex_rd)));

  function automatic fwd_sel_t pick(input logic [4:0] rs);
    if (i_mem_regwrite && i_mem_rd != 5'd0 && i_mem_rd == rs)
      return FWD_MEM;
    else if (i_wb_regwrite && i_wb_rd != 5'd0 && i_wb_rd == rs)
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  assign o_fwd_a = pick(i_ex_rs1);
  assign o_fwd_b = pick(i_ex_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: run/stall/flush/freeze sequencer for the 5-stage pipe.
// Ports: clk, rst_n (sync, active-low), bus (slave). Perf: PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2
`ifdef PIPE_HAZARD_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int FD = (FLUSH_DEPTH < 1) ? 1 :
                      (FLUSH_DEPTH > 3) ? 3 : FLUSH_DEPTH;
  localparam logic [1:0] FCNT_LD = 2'(FD - 1);

  pipe_state_t r_state, w_state_nxt;
  pipe_state_t r_ret, w_ret_nxt;
  logic [1:0]  r_fcnt, w_fcnt_nxt;

  logic     w_load_use;
  logic     w_mem_stall;
  fwd_sel_t w_fwd_a;
  fwd_sel_t w_fwd_b;
  logic     w_pc_en, w_if_id_en, w_id_ex_en;
  logic     w_ex_mem_en, w_mem_wb_en;
  logic     w_flush, w_bubble;

  hazard_detect u_hd (
    .i_id_instr     (bus.id_instr),
    .i_id_valid     (bus.id_valid),
    .i_ex_rd        (bus.ex_rd),
    .i_ex_memread   (bus.ex_memread),
    .i_ex_rs1       (bus.ex_rs1),
    .i_ex_rs2       (bus.ex_rs2),
    .i_mem_rd       (bus.mem_rd),
    .i_mem_regwrite (bus.mem_regwrite),
    .i_wb_rd        (bus.wb_rd),
    .i_wb_regwrite  (bus.wb_regwrite),
    .o_load_use     (w_load_use),
    .o_fwd_a        (w_fwd_a),
    .o_fwd_b        (w_fwd_b)
  );

  assign w_mem_stall = bus.dmem_req && !bus.dmem_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_ret   <= ST_RUN;
      r_fcnt  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret;
    w_fcnt_nxt  = r_fcnt;
    unique case (r_state)
      ST_RUN, ST_LDSTALL: begin
        if (w_mem_stall) begin
          w_state_nxt = ST_MEMWAIT;
          w_ret_nxt   = ST_RUN;
        end else if (bus.ex_redirect) begin
          w_state_nxt = (FD > 1) ? ST_FLUSH : ST_RUN;
          w_fcnt_nxt  = FCNT_LD;
        end else if (w_load_use && r_state == ST_RUN) begin
          w_state_nxt = ST_LDSTALL;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (w_mem_stall) begin
          w_state_nxt = ST_MEMWAIT;
          w_ret_nxt   = ST_FLUSH;
        end else begin
          w_fcnt_nxt  = r_fcnt - 2'd1;
          w_state_nxt = (r_fcnt == 2'd1) ? ST_RUN : ST_FLUSH;
        end
      end
      ST_MEMWAIT: begin
        if (bus.dmem_ack)
          w_state_nxt = r_ret;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_pc_en     = 1'b1;
    w_if_id_en  = 1'b1;
    w_id_ex_en  = 1'b1;
    w_ex_mem_en = 1'b1;
    w_mem_wb_en = 1'b1;
    w_flush     = 1'b0;
    w_bubble    = 1'b0;
    unique case (r_state)
      ST_RUN, ST_LDSTALL: begin
        if (w_mem_stall) begin
          {w_pc_en, w_if_id_en, w_id_ex_en,
           w_ex_mem_en, w_mem_wb_en} = 5'b0;
        end else if (bus.ex_redirect) begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
        end else if (w_load_use && r_state == ST_RUN) begin
          w_pc_en    = 1'b0;
          w_if_id_en = 1'b0;
          w_bubble   = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (w_mem_stall) begin
          {w_pc_en, w_if_id_en, w_id_ex_en,
           w_ex_mem_en, w_mem_wb_en} = 5'b0;
        end else begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
        end
      end
      ST_MEMWAIT: begin
        {w_pc_en, w_if_id_en, w_id_ex_en,
         w_ex_mem_en, w_mem_wb_en} = 5'b0;
      end
      default: ;
    endcase
  end

  assign bus.pc_en        = w_pc_en;
  assign bus.if_id_en     = w_if_id_en;
  assign bus.id_ex_en     = w_id_ex_en;
  assign bus.ex_mem_en    = w_ex_mem_en;
  assign bus.mem_wb_en    = w_mem_wb_en;
  assign bus.flush_if_id  = w_flush;
  assign bus.bubble_id_ex = w_bubble;
  assign bus.fwd_a        = w_fwd_a;
  assign bus.fwd_b        = w_fwd_b;
  assign bus.ctrl_state   = r_state;

`ifdef PIPE_HAZARD_PERF_EN
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_en)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.perf_stall_cnt = r_stall_cnt;
  assign bus.perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: event-level model checked every cycle,
// plus directed vectors with literal expectations.
module tb_pipe_hazard_ctrl;

  localparam int FD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.FLUSH_DEPTH(FD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // add x6,x5,x7 / add x6,x0,x7 / lui x5 (rs1 field 5)
  // sw x7,0(x2) / addi x6,x5,7
  localparam logic [31:0] I_ADD  = {7'd0, 5'd7, 5'd5, 3'd0, 5'd6, 7'b0110011};
  localparam logic [31:0] I_ADD0 = {7'd0, 5'd7, 5'd0, 3'd0, 5'd6, 7'b0110011};
  localparam logic [31:0] I_LUI  = {12'd0, 5'd5, 3'd0, 5'd5, 7'b0110111};
  localparam logic [31:0] I_SW   = {7'd0, 5'd7, 5'd2, 3'd2, 5'd0, 7'b0100011};
  localparam logic [31:0] I_ADDI = {12'd7, 5'd5, 3'd0, 5'd6, 7'b0010011};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Event view: bubbles still owed, frozen flag, stall already taken.
  int m_owed = 0;
  bit m_frozen = 0;
  bit m_stalled = 0;
  bit m_en = 0;
  int n_owed = 0;
  bit n_frozen = 0;
  bit n_stalled = 0;

  function automatic bit uses_rs1(input logic [6:0] op);
    return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  endfunction

  function automatic bit uses_rs2(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
  endfunction

  function automatic int fwd_of(input logic [4:0] rs);
    if (bus.mem_regwrite && bus.mem_rd != 0 && bus.mem_rd == rs) return 1;
    if (bus.wb_regwrite && bus.wb_rd != 0 && bus.wb_rd == rs) return 2;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (m_en) begin
      bit lu;
      int en, fl, bb, st;
      logic [6:0] op;
      logic [4:0] s1, s2;
      op = bus.id_instr[6:0];
      s1 = bus.id_instr[19:15];
      s2 = bus.id_instr[24:20];
      lu = bus.ex_memread && bus.ex_rd != 0 && bus.id_valid &&
           ((uses_rs1(op) && s1 == bus.ex_rd) ||
            (uses_rs2(op) && s2 == bus.ex_rd));
      st = m_frozen ? 3 : (m_owed > 0) ? 2 : m_stalled ? 1 : 0;
      en = 31; fl = 0; bb = 0;
      n_owed = m_owed; n_frozen = m_frozen; n_stalled = 0;
      if (m_frozen) begin
        en = 0;
        if (bus.dmem_ack) n_frozen = 0;
      end else if (bus.dmem_req && !bus.dmem_ack) begin
        en = 0;
        n_frozen = 1;
      end else if (m_owed > 0) begin
        fl = 1; bb = 1;
        n_owed = m_owed - 1;
      end else if (bus.ex_redirect) begin
        fl = 1; bb = 1;
        n_owed = FD - 1;
      end else if (lu && !m_stalled) begin
        en = 5'b00111; bb = 1;
        n_stalled = 1;
      end
      chk("enables", int'({bus.pc_en, bus.if_id_en, bus.id_ex_en,
                          bus.ex_mem_en, bus.mem_wb_en}), en);
      chk("flush_if_id", int'(bus.flush_if_id), fl);
      chk("bubble_id_ex", int'(bus.bubble_id_ex), bb);
      chk("ctrl_state", int'(bus.ctrl_state), st);
      chk("fwd_a", int'(bus.fwd_a), fwd_of(bus.ex_rs1));
      chk("fwd_b", int'(bus.fwd_b), fwd_of(bus.ex_rs2));
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owed = 0; m_frozen = 0; m_stalled = 0; m_en = 1;
      n_owed = 0; n_frozen = 0; n_stalled = 0;
    end else begin
      m_owed = n_owed; m_frozen = n_frozen; m_stalled = n_stalled;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    bus.id_instr = 32'h0000_0013;
    bus.id_valid = 0;
    bus.ex_rd = 0; bus.ex_memread = 0;
    bus.ex_rs1 = 0; bus.ex_rs2 = 0;
    bus.ex_redirect = 0;
    bus.mem_rd = 0; bus.mem_regwrite = 0;
    bus.wb_rd = 0; bus.wb_regwrite = 0;
    bus.dmem_req = 0; bus.dmem_ack = 0;
  endtask

  function automatic int ens();
    return int'({bus.pc_en, bus.if_id_en, bus.id_ex_en,
                 bus.ex_mem_en, bus.mem_wb_en});
  endfunction

  task automatic hazard(input logic [31:0] ins, input logic [4:0] rd);
    bus.id_instr = ins; bus.id_valid = 1;
    bus.ex_memread = 1; bus.ex_rd = rd;
  endtask

  initial begin
    clr();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    look();
    chk("rst_en", ens(), 31);
    chk("rst_flush", int'(bus.flush_if_id), 0);
    chk("rst_bub", int'(bus.bubble_id_ex), 0);
    chk("rst_fwd", int'({bus.fwd_a, bus.fwd_b}), 0);
    chk("rst_state", int'(bus.ctrl_state), 0);

    // load-use: one stall, then masked in LDSTALL
    tick(); hazard(I_ADD, 5'd5);
    look();
    chk("lu_pc", int'(bus.pc_en), 0);
    chk("lu_ifid", int'(bus.if_id_en), 0);
    chk("lu_bub", int'(bus.bubble_id_ex), 1);
    tick();
    bus.ex_rs1 = 5; bus.mem_rd = 5; bus.mem_regwrite = 1;
    look();
    chk("lds_state", int'(bus.ctrl_state), 1);
    chk("lds_pc", int'(bus.pc_en), 1);
    chk("lds_fwd_a", int'(bus.fwd_a), 1);
    tick(); clr();
    look();
    chk("lu_done", int'(bus.ctrl_state), 0);

    // redirect: FD flush cycles, state 0->2->0
    tick(); bus.ex_redirect = 1;
    look();
    chk("rd_fl0", int'(bus.flush_if_id), 1);
    chk("rd_st0", int'(bus.ctrl_state), 0);
    tick(); bus.ex_redirect = 0;
    look();
    chk("rd_fl1", int'(bus.flush_if_id), 1);
    chk("rd_st1", int'(bus.ctrl_state), 2);
    tick();
    look();
    chk("rd_fl2", int'(bus.flush_if_id), 0);
    chk("rd_st2", int'(bus.ctrl_state), 0);

    // freeze during FLUSH, ack 3 cycles after req -> 4 frozen
    tick(); bus.ex_redirect = 1;
    tick(); bus.ex_redirect = 0; bus.dmem_req = 1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) bus.dmem_ack = 1;
      look();
      chk("mw_en", ens(), 0);
      chk("mw_fl", int'(bus.flush_if_id), 0);
      tick();
    end
    bus.dmem_req = 0; bus.dmem_ack = 0;
    look();
    chk("mw_resume_st", int'(bus.ctrl_state), 2);
    chk("mw_resume_fl", int'(bus.flush_if_id), 1);
    tick();
    look();
    chk("mw_after", int'(bus.ctrl_state), 0);

    // load-use together with redirect: flush wins
    tick(); hazard(I_ADD, 5'd5); bus.ex_redirect = 1;
    look();
    chk("lur_pc", int'(bus.pc_en), 1);
    chk("lur_fl", int'(bus.flush_if_id), 1);
    tick(); bus.ex_redirect = 0;
    look();
    chk("lur_st", int'(bus.ctrl_state), 2);
    tick(); clr();

    // decode corner cases
    tick(); hazard(I_LUI, 5'd5);
    look(); chk("lui_nostall", int'(bus.pc_en), 1);
    tick(); hazard(I_ADD0, 5'd0);
    look(); chk("x0_nostall", int'(bus.pc_en), 1);
    tick(); hazard(I_ADDI, 5'd7);
    look(); chk("addi_rs2", int'(bus.pc_en), 1);
    tick(); hazard(I_ADD, 5'd5); bus.id_valid = 0;
    look(); chk("novalid", int'(bus.pc_en), 1);
    tick(); hazard(I_SW, 5'd7);
    look(); chk("sw_stall", int'(bus.pc_en), 0);
    tick(); clr();
    look(); chk("sw_lds", int'(bus.ctrl_state), 1);
    tick();

    // forwarding priority
    bus.mem_rd = 9; bus.wb_rd = 9; bus.ex_rs2 = 9;
    bus.mem_regwrite = 1; bus.wb_regwrite = 1;
    look(); chk("fwd_mem", int'(bus.fwd_b), 1);
    tick(); bus.mem_regwrite = 0;
    look(); chk("fwd_wb", int'(bus.fwd_b), 2);
    tick(); bus.mem_rd = 0; bus.wb_rd = 0; bus.ex_rs2 = 0;
    bus.mem_regwrite = 1; bus.wb_regwrite = 1;
    look(); chk("fwd_x0", int'(bus.fwd_b), 0);
    tick(); clr();

    // same-cycle ack: no freeze
    bus.dmem_req = 1; bus.dmem_ack = 1;
    look(); chk("ack0_en", ens(), 31);
    tick(); clr();
    look(); chk("ack0_st", int'(bus.ctrl_state), 0);

    // reset while frozen
    tick(); bus.dmem_req = 1;
    tick();
    look(); chk("rz_st", int'(bus.ctrl_state), 3);
    tick(); rst_n = 0;
    tick(); rst_n = 1; bus.dmem_req = 0;
    look();
    chk("rz_st0", int'(bus.ctrl_state), 0);
    chk("rz_en", ens(), 31);
`ifdef PIPE_HAZARD_PERF_EN
    chk("rz_pstall", int'(bus.perf_stall_cnt), 0);
    chk("rz_pflush", int'(bus.perf_flush_cnt), 0);
`endif

    // random soak against the model
    for (int i = 0; i < 300; i++) begin
      tick();
      bus.ex_redirect = ($urandom_range(7) == 0);
      bus.dmem_req = ($urandom_range(9) == 0);
      bus.dmem_ack = ($urandom_range(2) == 0);
      bus.ex_memread = $urandom_range(1);
      bus.ex_rd = 5'($urandom_range(3));
      bus.id_valid = $urandom_range(1);
      case ($urandom_range(4))
        0: bus.id_instr = I_ADD;
        1: bus.id_instr = I_LUI;
        2: bus.id_instr = I_SW;
        3: bus.id_instr = I_ADDI;
        default: bus.id_instr = I_ADD0;
      endcase
      bus.id_instr[19:15] = 5'($urandom_range(3));
      bus.id_instr[24:20] = 5'($urandom_range(3));
      bus.ex_rs1 = 5'($urandom_range(3));
      bus.ex_rs2 = 5'($urandom_range(3));
      bus.mem_rd = 5'($urandom_range(3));
      bus.wb_rd = 5'($urandom_range(3));
      bus.mem_regwrite = $urandom_range(1);
      bus.wb_regwrite = $urandom_range(1);
    end
    tick(); clr();
    look();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
